equiv_monitor: RTL and testbench

Synthesizable scoreboard: the receiving end of the spec-vs-impl stimulus stream. Each beat carries one input vector plus the spec and impl result words. The block compares them under a bit mask, counts vectors and failures, and logs mismatch records in a small FIFO that a host or trace port drains. It sits behind the enumerating stimulus generator in the function-translation regression harness, so equivalence checking can run in emulation without a simulator-side checker.

---
 rtl/equiv_monitor_if.sv | 28 ++
 rtl/equiv_monitor.sv | 117 +++++++++++
 tb/tb_equiv_monitor.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/equiv_monitor_if.sv
// Stimulus-beat and mismatch-log handshake bundle for equiv_monitor.
// master = stimulus source / log consumer, slave = the monitor.
interface equiv_monitor_if #(
   parameter int IN_WIDTH  = 4,
   parameter int WIDTH     = 24,
   parameter int CNT_WIDTH = 16
);
   logic                 cmp_valid;
   logic                 cmp_ready;
   logic [IN_WIDTH-1:0]  cmp_in;
   logic [WIDTH-1:0]     cmp_spec;
   logic [WIDTH-1:0]     cmp_impl;
   logic [WIDTH-1:0]     cmp_mask;
   logic                 log_valid;
   logic                 log_ready;
   logic [IN_WIDTH-1:0]  log_in;
   logic [WIDTH-1:0]     log_diff;
   logic [CNT_WIDTH-1:0] log_idx;

   modport master (
      output cmp_valid, cmp_in, cmp_spec, cmp_impl, cmp_mask, log_ready,
      input  cmp_ready, log_valid, log_in, log_diff, log_idx
   );
   modport slave (
      input  cmp_valid, cmp_in, cmp_spec, cmp_impl, cmp_mask, log_ready,
      output cmp_ready, log_valid, log_in, log_diff, log_idx
   );
endinterface

// File: rtl/equiv_monitor.sv
// Spec-vs-impl scoreboard: masked compare, saturating counters, FWFT mismatch log.
// Define EQUIV_MON_HALT_EN to stop accepting beats after the first mismatch.
module equiv_monitor #(
   parameter int IN_WIDTH  = 4,
   parameter int WIDTH     = 24,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 clear_i,
   equiv_monitor_if.slave       cmp_if,
   output logic [CNT_WIDTH-1:0] vec_count_o,
   output logic [CNT_WIDTH-1:0] fail_count_o,
   output logic                 fail_o,
   output logic                 overflow_o
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {ACTIVE, HALTED} state_e;

   typedef struct packed {
      logic [IN_WIDTH-1:0]  stim;
      logic [WIDTH-1:0]     diff;
      logic [CNT_WIDTH-1:0] idx;
   } rec_t;

   state_e               state_q, state_d;
   rec_t                 mem_q [DEPTH];
   rec_t                 head;
   logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
   logic [CNT_WIDTH-1:0] vec_q, vec_d, fcnt_q, fcnt_d;
   logic                 fail_q, fail_d, ovf_q, ovf_d;
   logic [WIDTH-1:0]     diff;
   logic                 ready, accept, mismatch, empty, full, pop, push;

   // Ready never looks at cmp_valid, so there is no valid-to-ready path.
   assign ready    = rst_n_i & ~clear_i & (state_q == ACTIVE);
   assign accept   = cmp_if.cmp_valid & ready;
   assign diff     = (cmp_if.cmp_spec ^ cmp_if.cmp_impl) & cmp_if.cmp_mask;
   assign mismatch = |diff;
   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[AW-1:0] == rd_q[AW-1:0]) & (wr_q[AW] != rd_q[AW]);
   assign pop      = ~empty & cmp_if.log_ready;
   assign push     = accept & mismatch & (~full | pop);
   assign head     = empty ? '0 : mem_q[rd_q[AW-1:0]];

   assign cmp_if.cmp_ready = ready;
   assign cmp_if.log_valid = ~empty;
   assign cmp_if.log_in    = head.stim;
   assign cmp_if.log_diff  = head.diff;
   assign cmp_if.log_idx   = head.idx;
   assign vec_count_o      = vec_q;
   assign fail_count_o     = fcnt_q;
   assign fail_o           = fail_q;
   assign overflow_o       = ovf_q;

   always_comb begin
      state_d = state_q;
      if (clear_i) state_d = ACTIVE;
`ifdef EQUIV_MON_HALT_EN
      else if (accept && mismatch) state_d = HALTED;
`endif
   end

   always_comb begin
      vec_d  = vec_q;
      fcnt_d = fcnt_q;
      fail_d = fail_q;
      ovf_d  = ovf_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      if (clear_i) begin
         vec_d  = '0;
         fcnt_d = '0;
         fail_d = 1'b0;
         ovf_d  = 1'b0;
         wr_d   = '0;
         rd_d   = '0;
      end else begin
         if (accept) vec_d = (&vec_q) ? vec_q : vec_q + 1'b1;
         if (accept && mismatch) begin
            fcnt_d = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;
            fail_d = 1'b1;
            if (full && !pop) ovf_d = 1'b1;
         end
         if (pop)  rd_d = rd_q + 1'b1;
         if (push) wr_d = wr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ACTIVE;
         vec_q   <= '0;
         fcnt_q  <= '0;
         fail_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         fcnt_q  <= fcnt_d;
         fail_q  <= fail_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   // Storage needs no reset: the head is forced to zero whenever the log is empty.
   always_ff @(posedge clk_i) begin
      if (push && !clear_i)
         mem_q[wr_q[AW-1:0]] <= '{stim: cmp_if.cmp_in, diff: diff, idx: vec_q};
   end
endmodule

// File: tb/tb_equiv_monitor.sv
// Bench for equiv_monitor: directed vectors, table, randomized run against a queue model.
module tb_equiv_monitor;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n, clear;
   logic [15:0] vec_count, fail_count;
   logic        fail, overflow;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      bit [3:0]  stim;
      bit [23:0] diff;
      bit [15:0] idx;
   } rec_t;

   typedef struct {
      bit [3:0]  stim;
      bit [23:0] s, im, m;
      bit        mis;
      bit [23:0] diff;
   } vec_t;

   rec_t        mq[$];
   int unsigned mvec, mfc;
   bit          mf, movf, mhalt;

   equiv_monitor_if #(.IN_WIDTH(4), .WIDTH(24), .CNT_WIDTH(16)) ifc();

   equiv_monitor #(.IN_WIDTH(4), .WIDTH(24), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .cmp_if(ifc),
      .vec_count_o(vec_count), .fail_count_o(fail_count),
      .fail_o(fail), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      mvec = 0; mfc = 0; mf = 0; movf = 0; mhalt = 0;
   endtask

   task automatic compare_all();
      chk("log_valid", ifc.log_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("log_in", ifc.log_in, mq[0].stim);
         chk("log_diff", ifc.log_diff, mq[0].diff);
         chk("log_idx", ifc.log_idx, mq[0].idx);
      end
      chk("vec_count", vec_count, mvec);
      chk("fail_count", fail_count, mfc);
      chk("fail", fail, mf);
      chk("overflow", overflow, movf);
   endtask

   // One clock: drive on the falling edge, advance the model, check just after the rising edge.
   task automatic cycle(input bit v, input bit [3:0] stim, input bit [23:0] s, input bit [23:0] im,
                        input bit [23:0] m, input bit lr, input bit clr);
      bit        mready, acc;
      bit [23:0] d;
      @(negedge clk);
      ifc.cmp_valid = v; ifc.cmp_in = stim; ifc.cmp_spec = s; ifc.cmp_impl = im;
      ifc.cmp_mask = m; ifc.log_ready = lr; clear = clr;
      mready = !clr && !mhalt;
      #1 chk("cmp_ready", ifc.cmp_ready, mready);
      acc = v && mready;
      d = (s ^ im) & m;
      if (clr) model_clear();
      else begin
         if (lr && mq.size() != 0) void'(mq.pop_front());
         if (acc) begin
            if (d != 0) begin
               if (mfc != 16'hFFFF) mfc++;
               mf = 1;
`ifdef EQUIV_MON_HALT_EN
               mhalt = 1;
`endif
               if (mq.size() < DEPTH) mq.push_back('{stim, d, mvec[15:0]});
               else movf = 1;
            end
            if (mvec != 16'hFFFF) mvec++;
         end
      end
      @(posedge clk);
      #1 compare_all();
   endtask

   task automatic idle(input bit lr);
      cycle(0, 4'h0, 24'h0, 24'h0, 24'h0, lr, 0);
   endtask

   task automatic mis_beat(input bit [3:0] stim, input bit lr);
      cycle(1, stim, 24'h000000, 24'h000010 << stim[2:0], 24'hFFFFFF, lr, 0);
   endtask

   vec_t tbl[8];
   int   exp_fc;

   initial begin
      tbl[0] = '{4'h1, 24'h000001, 24'h000003, 24'hFFFFFF, 1'b1, 24'h000002};
      tbl[1] = '{4'h2, 24'h000001, 24'h000003, 24'hFFFFFD, 1'b0, 24'h000000};
      tbl[2] = '{4'h3, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1'b1, 24'hFFFFFF};
      tbl[3] = '{4'h4, 24'hFFFFFF, 24'h000000, 24'h000000, 1'b0, 24'h000000};
      tbl[4] = '{4'h5, 24'h123456, 24'h123456, 24'hFFFFFF, 1'b0, 24'h000000};
      tbl[5] = '{4'h6, 24'h800000, 24'h000000, 24'hF00000, 1'b1, 24'h800000};
      tbl[6] = '{4'h7, 24'hABCDEF, 24'hABCDEE, 24'hFFFFFE, 1'b0, 24'h000000};
      tbl[7] = '{4'h8, 24'hABCDEF, 24'hABCDEE, 24'h000001, 1'b1, 24'h000001};

      rst_n = 0; clear = 0;
      ifc.cmp_valid = 0; ifc.cmp_in = 0; ifc.cmp_spec = 0; ifc.cmp_impl = 0;
      ifc.cmp_mask = 0; ifc.log_ready = 0;
      model_clear();
      #23;
      chk("rst_ready", ifc.cmp_ready, 0);
      chk("rst_log_valid", ifc.log_valid, 0);
      chk("rst_log_in", ifc.log_in, 0);
      chk("rst_log_diff", ifc.log_diff, 0);
      chk("rst_log_idx", ifc.log_idx, 0);
      chk("rst_vec", vec_count, 0);
      chk("rst_fcnt", fail_count, 0);
      chk("rst_fail", fail, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk) rst_n = 1;
      #1 chk("ready_after_rst", ifc.cmp_ready, 1);

      for (int i = 0; i < 64; i++) cycle(1, i[3:0], 24'h00A5F0, 24'h00A5F0, 24'hFFFFFF, 1, 0);
      chk("match64_vec", vec_count, 64);
      chk("match64_fcnt", fail_count, 0);
      chk("match64_fail", fail, 0);

      cycle(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(1, 4'h0, 24'h00A5F0, 24'h00A5F0, 24'hFFFFFF, 0, 0);
      cycle(1, 4'h9, 24'h000001, 24'h000003, 24'hFFFFFF, 0, 0);
      chk("b5_log_valid", ifc.log_valid, 1);
      chk("b5_log_diff", ifc.log_diff, 24'h000002);
      chk("b5_log_idx", ifc.log_idx, 5);
      chk("b5_fail", fail, 1);
      cycle(1, 4'h9, 24'h000001, 24'h000003, 24'hFFFFFD, 0, 0);
      chk("mask_fcnt", fail_count, 1);

`ifndef EQUIV_MON_HALT_EN
      cycle(0, 0, 0, 0, 0, 0, 1);
      exp_fc = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1, tbl[i].stim, tbl[i].s, tbl[i].im, tbl[i].m, 1, 0);
         exp_fc += int'(tbl[i].mis);
         chk("tbl_fcnt", fail_count, exp_fc);
         chk("tbl_valid", ifc.log_valid, tbl[i].mis);
         if (tbl[i].mis) begin
            chk("tbl_diff", ifc.log_diff, tbl[i].diff);
            chk("tbl_idx", ifc.log_idx, i);
            chk("tbl_in", ifc.log_in, tbl[i].stim);
         end
      end

      cycle(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) mis_beat(i[3:0], 0);
      chk("ovf_set", overflow, 1);
      chk("ovf_fcnt", fail_count, 6);
      for (int k = 0; k < 4; k++) begin
         chk("ovf_order", ifc.log_idx, k);
         idle(1);
      end
      chk("ovf_drained", ifc.log_valid, 0);

      cycle(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) mis_beat(i[3:0], 0);
      chk("full_no_ovf", overflow, 0);
      mis_beat(4'h4, 1);
      chk("poppush_ovf", overflow, 0);
      chk("poppush_fcnt", fail_count, 5);
      for (int k = 1; k < 5; k++) begin
         chk("poppush_order", ifc.log_idx, k);
         idle(1);
      end
`else
      cycle(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) cycle(1, 4'h0, 24'h00A5F0, 24'h00A5F0, 24'hFFFFFF, 0, 0);
      mis_beat(4'hA, 0);
      chk("halt_idx", ifc.log_idx, 10);
      cycle(1, 4'h0, 24'h00A5F0, 24'h00A5F0, 24'hFFFFFF, 0, 0);
      chk("halt_ready", ifc.cmp_ready, 0);
      chk("halt_vec", vec_count, 11);
      cycle(0, 0, 0, 0, 0, 0, 1);
      chk("halt_clr_vec", vec_count, 0);
      chk("halt_clr_fcnt", fail_count, 0);
      chk("halt_ready_after", ifc.cmp_ready, 1);
`endif

      cycle(0, 0, 0, 0, 0, 0, 1);
      for (int n = 0; n < 400; n++) begin
         bit [23:0] s, im, m;
         bit        v, lr, clr;
         s   = 24'($urandom);
         im  = ($urandom_range(0, 1) == 0) ? s : s ^ (24'h1 << $urandom_range(0, 23));
         m   = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'hFFFFFF;
         v   = $urandom_range(0, 3) != 0;
         lr  = $urandom_range(0, 2) == 0;
         clr = $urandom_range(0, 40) == 0;
         cycle(v, 4'($urandom), s, im, m, lr, clr);
      end

      cycle(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) mis_beat(i[3:0], 0);
      chk("pre_rst_valid", ifc.log_valid, 1);
      @(negedge clk);
      ifc.cmp_valid = 1; ifc.cmp_spec = 24'h1; ifc.cmp_impl = 24'h0; ifc.cmp_mask = 24'hFFFFFF;
      #2 rst_n = 0;
      #1;
      chk("midrst_valid", ifc.log_valid, 0);
      chk("midrst_vec", vec_count, 0);
      chk("midrst_fcnt", fail_count, 0);
      chk("midrst_fail", fail, 0);
      chk("midrst_ready", ifc.cmp_ready, 0);
      ifc.cmp_valid = 0;
      @(negedge clk) rst_n = 1;
      model_clear();
      #1 chk("midrst_ready_after", ifc.cmp_ready, 1);
      idle(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
